// File: rtl/chirp_sched_pkg.sv
// Shared types and constants for the chirp profile scheduler.
package chirp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [1:0] FIELD_COUNTER_MAX = 2'd0;
    localparam logic [1:0] FIELD_TUNING_COEF = 2'd1;
    localparam logic [1:0] FIELD_FREQ_OFFSET = 2'd2;
    localparam logic [1:0] FIELD_REPEAT      = 2'd3;

    localparam logic [31:0] DEF_COUNTER_MAX = 32'h0000_0FFF;
    localparam logic [31:0] DEF_TUNING_COEF = 32'h0000_0001;
    localparam logic [31:0] DEF_FREQ_OFFSET = 32'h0000_0600;

    typedef struct packed {
        logic [31:0] counter_max;
        logic [31:0] tuning_coef;
        logic [31:0] freq_offset;
        logic [15:0] rep_count;
    } profile_t;

    localparam profile_t DEF_PROFILE = '{
        counter_max: DEF_COUNTER_MAX,
        tuning_coef: DEF_TUNING_COEF,
        freq_offset: DEF_FREQ_OFFSET,
        rep_count:   16'h0000
    };

    function automatic profile_t apply_write(input profile_t p, input logic [1:0] field,
                                             input logic [31:0] data);
        profile_t r;
        r = p;
        case (field)
            FIELD_COUNTER_MAX: r.counter_max = data;
            FIELD_TUNING_COEF: r.tuning_coef = data;
            FIELD_FREQ_OFFSET: r.freq_offset = data;
            default:           r.rep_count   = data[15:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chirp_profile_table.sv
// Profile register file with registered read port feeding the chirp parameter output.
// Build option CHIRP_SCHED_SHADOW_EN: double-buffered table swapped on commit.
module chirp_profile_table
    import chirp_sched_pkg::*;
#(
    parameter int NUM_PROFILES = 8,
    parameter int IDX_W        = $clog2(NUM_PROFILES)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_field,
    input  logic [31:0]      wr_data,
    input  logic             commit,
    input  logic             swap_ok,
    input  logic [IDX_W-1:0] rd_addr,
    input  logic             load_en,
    output logic [95:0]      rd_params,
    output logic [15:0]      rd_repeat
);

    profile_t rd_prof;

`ifdef CHIRP_SCHED_SHADOW_EN
    profile_t bank [2][NUM_PROFILES];
    logic     bank_sel;
    logic     pending;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NUM_PROFILES; i++)
                    bank[b][i] <= DEF_PROFILE;
            bank_sel <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (wr_en)
                bank[~bank_sel][wr_addr] <= apply_write(bank[~bank_sel][wr_addr], wr_field, wr_data);
            // a commit arriving on the swap cycle stays pending for the next swap
            if (pending && swap_ok) begin
                bank_sel <= ~bank_sel;
                pending  <= commit;
            end else if (commit) begin
                pending <= 1'b1;
            end
        end
    end

    assign rd_prof = bank[bank_sel][rd_addr];
`else
    profile_t bank [NUM_PROFILES];
    logic     unused_cfg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PROFILES; i++)
                bank[i] <= DEF_PROFILE;
        end else if (wr_en) begin
            bank[wr_addr] <= apply_write(bank[wr_addr], wr_field, wr_data);
        end
    end

    assign rd_prof    = bank[rd_addr];
    assign unused_cfg = commit ^ swap_ok;
`endif

    assign rd_repeat = rd_prof.rep_count;

    // read captures the pre-write contents when a write hits the same slot
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            rd_params <= {DEF_FREQ_OFFSET, DEF_TUNING_COEF, DEF_COUNTER_MAX};
        else if (load_en)
            rd_params <= {rd_prof.freq_offset, rd_prof.tuning_coef, rd_prof.counter_max};
    end

endmodule

// File: rtl/chirp_profile_scheduler.sv
// Steps through the profile table on chirp_done, holding each profile for repeat+1 chirps.
// Build option CHIRP_SCHED_SHADOW_EN enables the double-buffered table.
//
// state | meaning
// IDLE  | sequencing stopped, params_valid low, outputs held
// LOAD  | table[idx] captured into outputs, repeat counter reloaded
// ARMED | params_valid high, waiting for chirp_done
module chirp_profile_scheduler
    import chirp_sched_pkg::*;
#(
    parameter int NUM_PROFILES = 8,
    parameter int IDX_W        = $clog2(NUM_PROFILES)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cfg_wr_en,
    input  logic [IDX_W-1:0] cfg_wr_addr,
    input  logic [1:0]       cfg_wr_field,
    input  logic [31:0]      cfg_wr_data,
    input  logic             cfg_commit,
    input  logic [IDX_W:0]   seq_length,
    input  logic             seq_enable,
    input  logic             seq_restart,
    input  logic             chirp_done,
    output logic [127:0]     chirp_parameters_out,
    output logic             params_valid,
    output logic [IDX_W-1:0] profile_index,
    output logic             sweep_done,
    output logic [15:0]      sweep_count
);

    localparam logic [IDX_W:0] NUM_P = (IDX_W+1)'(NUM_PROFILES);
    localparam logic [IDX_W:0] ONE_P = (IDX_W+1)'(1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [15:0]      rep_cnt, rep_cnt_next;
    logic [15:0]      sweep_count_next;
    logic             sweep_done_next;
    logic [IDX_W:0]   len_eff;
    logic             at_last;
    logic             load_en;
    logic             wrap;
    logic [95:0]      rd_params;
    logic [15:0]      rd_repeat;

    // >= rather than == so a length shrunk below idx+1 wraps on the next advance
    always_comb begin
        len_eff = seq_length;
        if (seq_length == '0)
            len_eff = ONE_P;
        else if (seq_length > NUM_P)
            len_eff = NUM_P;
        at_last = ({1'b0, idx} >= (len_eff - ONE_P));
    end

    always_comb begin
        state_next       = state;
        idx_next         = idx;
        rep_cnt_next     = rep_cnt;
        sweep_count_next = sweep_count;
        sweep_done_next  = 1'b0;
        load_en          = 1'b0;
        wrap             = 1'b0;
        if (!seq_enable) begin
            state_next = IDLE;
        end else if (seq_restart) begin
            idx_next         = '0;
            sweep_count_next = '0;
            state_next       = LOAD;
        end else begin
            case (state)
                IDLE: state_next = LOAD;
                LOAD: begin
                    load_en      = 1'b1;
                    rep_cnt_next = rd_repeat;
                    state_next   = ARMED;
                end
                ARMED: begin
                    if (chirp_done) begin
                        if (rep_cnt != 16'd0) begin
                            rep_cnt_next = rep_cnt - 16'd1;
                        end else begin
                            state_next = LOAD;
                            if (at_last) begin
                                idx_next        = '0;
                                wrap            = 1'b1;
                                sweep_done_next = 1'b1;
                                if (sweep_count != 16'hFFFF)
                                    sweep_count_next = sweep_count + 16'd1;
                            end else begin
                                idx_next = idx + 1'b1;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            idx           <= '0;
            rep_cnt       <= '0;
            sweep_count   <= '0;
            sweep_done    <= 1'b0;
            params_valid  <= 1'b0;
            profile_index <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            rep_cnt      <= rep_cnt_next;
            sweep_count  <= sweep_count_next;
            sweep_done   <= sweep_done_next;
            params_valid <= (state_next == ARMED);
            if (load_en)
                profile_index <= idx;
        end
    end

    chirp_profile_table #(
        .NUM_PROFILES (NUM_PROFILES),
        .IDX_W        (IDX_W)
    ) u_table (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_en     (cfg_wr_en),
        .wr_addr   (cfg_wr_addr),
        .wr_field  (cfg_wr_field),
        .wr_data   (cfg_wr_data),
        .commit    (cfg_commit),
        .swap_ok   ((state == IDLE) || wrap),
        .rd_addr   (idx),
        .load_en   (load_en),
        .rd_params (rd_params),
        .rd_repeat (rd_repeat)
    );

    assign chirp_parameters_out = {32'h0, rd_params};

endmodule

// File: tb/tb_chirp_profile_scheduler.sv
// Directed self-checking bench for chirp_profile_scheduler (single-bank build).
module tb_chirp_profile_scheduler;

    logic         aclk;
    logic         aresetn;
    logic         cfg_wr_en;
    logic [2:0]   cfg_wr_addr;
    logic [1:0]   cfg_wr_field;
    logic [31:0]  cfg_wr_data;
    logic         cfg_commit;
    logic [3:0]   seq_length;
    logic         seq_enable;
    logic         seq_restart;
    logic         chirp_done;
    logic [127:0] chirp_parameters_out;
    logic         params_valid;
    logic [2:0]   profile_index;
    logic         sweep_done;
    logic [15:0]  sweep_count;

    localparam logic [127:0] DEF_PARAMS = {32'h0, 32'h0600, 32'h1, 32'h0FFF};

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] freq;
        logic        adv;
        logic        sd;
        logic [15:0] cnt;
    } vec_t;

    vec_t       vecs [12];
    logic [2:0] l8_seq [11];
    int         n_checks = 0;
    int         n_fail   = 0;

    chirp_profile_scheduler #(.NUM_PROFILES(8)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_wr_addr          (cfg_wr_addr),
        .cfg_wr_field         (cfg_wr_field),
        .cfg_wr_data          (cfg_wr_data),
        .cfg_commit           (cfg_commit),
        .seq_length           (seq_length),
        .seq_enable           (seq_enable),
        .seq_restart          (seq_restart),
        .chirp_done           (chirp_done),
        .chirp_parameters_out (chirp_parameters_out),
        .params_valid         (params_valid),
        .profile_index        (profile_index),
        .sweep_done           (sweep_done),
        .sweep_count          (sweep_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_params"}, chirp_parameters_out, DEF_PARAMS);
        check({tag, "_valid"}, {127'b0, params_valid}, 128'd0);
        check({tag, "_index"}, {125'b0, profile_index}, 128'd0);
        check({tag, "_sweep_done"}, {127'b0, sweep_done}, 128'd0);
        check({tag, "_sweep_count"}, {112'b0, sweep_count}, 128'd0);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [1:0] field, input logic [31:0] data);
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = addr;
        cfg_wr_field = field;
        cfg_wr_data  = data;
        tick();
        cfg_wr_en    = 1'b0;
    endtask

    task automatic chirp();
        chirp_done = 1'b1;
        tick();
        chirp_done = 1'b0;
        tick();
    endtask

    task automatic restart();
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        check("restart_count", {112'b0, sweep_count}, 128'd0);
        tick();
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h100, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{3'd0, 32'h100, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{3'd1, 32'h200, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{3'd2, 32'h300, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{3'd2, 32'h300, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{3'd2, 32'h300, 1'b1, 1'b1, 16'd1};
        vecs[6]  = '{3'd0, 32'h100, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{3'd0, 32'h100, 1'b1, 1'b0, 16'd1};
        vecs[8]  = '{3'd1, 32'h200, 1'b1, 1'b0, 16'd1};
        vecs[9]  = '{3'd2, 32'h300, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{3'd2, 32'h300, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{3'd2, 32'h300, 1'b1, 1'b1, 16'd2};
        l8_seq = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        aresetn      = 1'b1;
        cfg_wr_en    = 1'b0;
        cfg_wr_addr  = '0;
        cfg_wr_field = '0;
        cfg_wr_data  = '0;
        cfg_commit   = 1'b0;
        seq_length   = 4'd1;
        seq_enable   = 1'b0;
        seq_restart  = 1'b0;
        chirp_done   = 1'b0;
        #2 aresetn = 1'b0;
        tick();
        tick();
        check_reset("por");
        aresetn = 1'b1;
        tick();

        // start-up latency with the default table
        seq_enable = 1'b1;
        tick();
        check("start_valid_load", {127'b0, params_valid}, 128'd0);
        tick();
        check("start_valid", {127'b0, params_valid}, 128'd1);
        check("start_params", chirp_parameters_out, DEF_PARAMS);
        check("start_index", {125'b0, profile_index}, 128'd0);

        // program three profiles in IDLE
        seq_enable = 1'b0;
        tick();
        wr(3'd0, 2'd2, 32'h100);
        wr(3'd1, 2'd2, 32'h200);
        wr(3'd2, 2'd2, 32'h300);
        wr(3'd0, 2'd3, 32'd1);
        wr(3'd2, 2'd3, 32'd2);
        seq_length = 4'd3;
        seq_enable = 1'b1;
        tick();
        tick();

        for (int k = 0; k < 12; k++) begin
            check($sformatf("seq%0d_index", k), {125'b0, profile_index}, {125'b0, vecs[k].idx});
            check($sformatf("seq%0d_freq", k), {96'b0, chirp_parameters_out[95:64]}, {96'b0, vecs[k].freq});
            chirp_done = 1'b1;
            tick();
            chirp_done = 1'b0;
            check($sformatf("seq%0d_sweep_done", k), {127'b0, sweep_done}, {127'b0, vecs[k].sd});
            check($sformatf("seq%0d_valid", k), {127'b0, params_valid}, {127'b0, ~vecs[k].adv});
            check($sformatf("seq%0d_count", k), {112'b0, sweep_count}, {112'b0, vecs[k].cnt});
            tick();
        end

        // seq_length 0 behaves as a single-slot sequence
        seq_length = 4'd0;
        restart();
        for (int k = 0; k < 4; k++) begin
            chirp();
            check($sformatf("len0_%0d_index", k), {125'b0, profile_index}, 128'd0);
        end
        check("len0_count", {112'b0, sweep_count}, 128'd2);

        // seq_length above NUM_PROFILES clamps to all 8 slots
        seq_length = 4'd12;
        restart();
        for (int k = 0; k < 11; k++) begin
            chirp();
            check($sformatf("len12_%0d_index", k), {125'b0, profile_index}, {125'b0, l8_seq[k]});
            if (k == 9)
                check("len12_slot7_freq", {96'b0, chirp_parameters_out[95:64]}, 128'h600);
        end
        check("len12_count", {112'b0, sweep_count}, 128'd1);

        // restart wins over a wrapping chirp_done
        seq_length = 4'd3;
        restart();
        for (int k = 0; k < 11; k++)
            chirp();
        check("prio_index_pre", {125'b0, profile_index}, 128'd2);
        check("prio_count_pre", {112'b0, sweep_count}, 128'd1);
        chirp_done  = 1'b1;
        seq_restart = 1'b1;
        tick();
        chirp_done  = 1'b0;
        seq_restart = 1'b0;
        check("prio_sweep_done", {127'b0, sweep_done}, 128'd0);
        check("prio_count", {112'b0, sweep_count}, 128'd0);
        tick();
        check("prio_index", {125'b0, profile_index}, 128'd0);
        check("prio_freq", {96'b0, chirp_parameters_out[95:64]}, 128'h100);

        // dropping seq_enable holds outputs
        seq_enable = 1'b0;
        tick();
        check("disable_valid", {127'b0, params_valid}, 128'd0);
        check("disable_freq", {96'b0, chirp_parameters_out[95:64]}, 128'h100);
        check("disable_index", {125'b0, profile_index}, 128'd0);

        // live write to the armed slot shows only at its next LOAD
        seq_enable = 1'b1;
        tick();
        tick();
        chirp();
        chirp();
        check("live_index", {125'b0, profile_index}, 128'd1);
        wr(3'd1, 2'd2, 32'h777);
        check("live_freq_held", {96'b0, chirp_parameters_out[95:64]}, 128'h200);
        chirp();
        check("live_freq_next", {96'b0, chirp_parameters_out[95:64]}, 128'h300);
        for (int k = 0; k < 5; k++)
            chirp();
        check("live_index_again", {125'b0, profile_index}, 128'd1);
        check("live_freq_new", {96'b0, chirp_parameters_out[95:64]}, 128'h777);
        check("live_count", {112'b0, sweep_count}, 128'd1);

        // asynchronous reset during LOAD
        chirp_done = 1'b1;
        tick();
        chirp_done = 1'b0;
        aresetn = 1'b0;
        #1;
        check_reset("async");
        #2 aresetn = 1'b1;
        tick();
        tick();
        check("post_reset_valid", {127'b0, params_valid}, 128'd1);
        check("post_reset_params", chirp_parameters_out, DEF_PARAMS);
        check("post_reset_index", {125'b0, profile_index}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
